// File: rtl/bus_slave_sel_pkg.sv
// Shared definitions for the bus slave selector: chip-select levels, slave indices,
// default geometry and the controller state encoding.
package bus_slave_sel_pkg;

  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  localparam int SLAVE_NUM_DEF = 8;
  localparam int IDX_W_DEF     = 3;

  localparam int SLAVE_IDX_0 = 0;
  localparam int SLAVE_IDX_1 = 1;
  localparam int SLAVE_IDX_2 = 2;
  localparam int SLAVE_IDX_3 = 3;
  localparam int SLAVE_IDX_4 = 4;
  localparam int SLAVE_IDX_5 = 5;
  localparam int SLAVE_IDX_6 = 6;
  localparam int SLAVE_IDX_7 = 7;

  typedef enum logic [1:0] {
    BUS_SEL_IDLE   = 2'd0,
    BUS_SEL_ACCESS = 2'd1,
    BUS_SEL_ERROR  = 2'd2
  } bus_sel_state_e;

endpackage

// File: rtl/bus_sel_watchdog.sv
// 8-bit access watchdog: counts enabled cycles, clears on request and flags
// the cycle in which the count reaches LIMIT-1.
module bus_sel_watchdog #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expire
);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = 8'd0;
    else if (en)
      cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset)
      cnt_q <= 8'd0;
    else
      cnt_q <= cnt_d;
  end

  assign expire = en && (cnt_q == 8'(LIMIT - 1));

endmodule

// File: rtl/bus_slave_sel.sv
// Registered bus slave selector: decodes the slave index, holds one active-low chip
// select until ready, flags unmapped or (with BUS_SLAVE_SEL_TIMEOUT_EN) timed-out accesses.
module bus_slave_sel
  import bus_slave_sel_pkg::*;
#(
  parameter int                   SLAVE_NUM  = SLAVE_NUM_DEF,
  parameter int                   ADDR_W     = 30,
  parameter int                   IDX_W      = IDX_W_DEF,
  parameter logic [SLAVE_NUM-1:0] SLAVE_MASK = {SLAVE_NUM{1'b1}},
  parameter int                   TIMEOUT    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADDR_W-1:0]    m_addr,
  input  logic                 m_as_,
  output logic [SLAVE_NUM-1:0] s_cs_,
  input  logic [SLAVE_NUM-1:0] s_rdy_,
  output logic                 m_rdy_,
  output logic                 m_err,
  output logic                 busy,
  output logic [IDX_W-1:0]     cur_idx
);

  bus_sel_state_e       state_q, state_d;
  logic [SLAVE_NUM-1:0] cs_q, cs_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [IDX_W-1:0]     addr_idx;
  logic                 mapped;
  logic                 sel_rdy_;
  logic                 expire;

  assign addr_idx = m_addr[ADDR_W-1 -: IDX_W];
  assign mapped   = (int'(addr_idx) < SLAVE_NUM) && SLAVE_MASK[addr_idx];
  assign sel_rdy_ = s_rdy_[idx_q];

`ifdef BUS_SLAVE_SEL_TIMEOUT_EN
  // Timer runs only while ACCESS persists; any exit clears it on the same edge.
  bus_sel_watchdog #(
    .LIMIT (TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clr    (state_d != BUS_SEL_ACCESS),
    .en     (state_q == BUS_SEL_ACCESS),
    .expire (expire)
  );
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT > 0);
  assign expire         = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cs_d    = cs_q;
    idx_d   = idx_q;
    unique case (state_q)
      BUS_SEL_IDLE: begin
        if (m_as_ == ENABLE_) begin
          idx_d = addr_idx;
          if (mapped) begin
            state_d        = BUS_SEL_ACCESS;
            cs_d           = {SLAVE_NUM{DISABLE_}};
            cs_d[addr_idx] = ENABLE_;
          end else begin
            state_d = BUS_SEL_ERROR;
          end
        end
      end
      BUS_SEL_ACCESS: begin
        // Ready takes priority over a simultaneous watchdog expiry.
        if (sel_rdy_ == ENABLE_) begin
          state_d = BUS_SEL_IDLE;
          cs_d    = {SLAVE_NUM{DISABLE_}};
        end else if (expire) begin
          state_d = BUS_SEL_ERROR;
          cs_d    = {SLAVE_NUM{DISABLE_}};
        end
      end
      BUS_SEL_ERROR: begin
        state_d = BUS_SEL_IDLE;
      end
      default: begin
        state_d = BUS_SEL_IDLE;
        cs_d    = {SLAVE_NUM{DISABLE_}};
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= BUS_SEL_IDLE;
      cs_q    <= {SLAVE_NUM{DISABLE_}};
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cs_q    <= cs_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    m_rdy_ = DISABLE_;
    m_err  = 1'b0;
    case (state_q)
      BUS_SEL_ACCESS: m_rdy_ = sel_rdy_;
      BUS_SEL_ERROR: begin
        m_rdy_ = ENABLE_;
        m_err  = 1'b1;
      end
      default: ;
    endcase
  end

  assign s_cs_   = cs_q;
  assign busy    = (state_q != BUS_SEL_IDLE);
  assign cur_idx = idx_q;

endmodule

// File: tb/tb_bus_slave_sel.sv
// Randomized and directed bench for bus_slave_sel against a transaction-level model.
module tb_bus_slave_sel;

`ifdef BUS_SLAVE_SEL_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [29:0] m_addr;
  logic        m_as_;
  logic [7:0]  s_cs_;
  logic [7:0]  s_rdy_;
  logic        m_rdy_;
  logic        m_err;
  logic        busy;
  logic [2:0]  cur_idx;

  bus_slave_sel #(
    .SLAVE_NUM  (8),
    .ADDR_W     (30),
    .IDX_W      (3),
    .SLAVE_MASK (8'h7F),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .m_addr  (m_addr),
    .m_as_   (m_as_),
    .s_cs_   (s_cs_),
    .s_rdy_  (s_rdy_),
    .m_rdy_  (m_rdy_),
    .m_err   (m_err),
    .busy    (busy),
    .cur_idx (cur_idx)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Transaction-level model: mode 0 idle, 1 slave selected, 2 error pulse.
  logic [7:0] mask = 8'h7F;
  int         mode = 0;
  int         age  = 0;
  logic [2:0] msel = 3'd0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h (t=%0t)", tag, act, exp, $time);
  endtask

  task automatic step();
    logic [7:0] ecs;
    @(negedge clk);
    ecs = 8'hFF;
    if (mode == 1) ecs[msel] = 1'b0;
    check_eq("s_cs_",   {24'd0, s_cs_}, {24'd0, ecs});
    check_eq("m_rdy_",  {31'd0, m_rdy_}, (mode == 1) ? {31'd0, s_rdy_[msel]} : (mode == 2) ? 32'd0 : 32'd1);
    check_eq("m_err",   {31'd0, m_err}, (mode == 2) ? 32'd1 : 32'd0);
    check_eq("busy",    {31'd0, busy},  (mode != 0) ? 32'd1 : 32'd0);
    check_eq("cur_idx", {29'd0, cur_idx}, {29'd0, msel});
    @(posedge clk);
    if (reset) begin
      mode = 0; age = 0; msel = 3'd0;
    end else begin
      case (mode)
        0: if (!m_as_) begin
             msel = m_addr[29:27];
             mode = mask[msel] ? 1 : 2;
             age  = 0;
           end
        1: begin
             age++;
             if (!s_rdy_[msel]) mode = 0;
             else if (TO_EN && age >= TIMEOUT) mode = 2;
           end
        default: mode = 0;
      endcase
    end
    #1;
  endtask

  task automatic strobe(input logic [29:0] addr);
    m_addr = addr;
    m_as_  = 1'b0;
    step();
    m_as_  = 1'b1;
  endtask

  initial begin
    reset  = 1'b1;
    m_as_  = 1'b0;
    m_addr = 30'd0;
    s_rdy_ = 8'hFF;
    repeat (3) step();
    reset = 1'b0;
    step();
    // Strobe held low at release started slave 0; finish it.
    m_as_  = 1'b1;
    s_rdy_ = 8'hFE;
    step();
    s_rdy_ = 8'hFF;
    step();

    // Normal access to slave 2
    strobe(30'h1000_0000);
    check_eq("cs_slave2", {24'd0, s_cs_}, 32'hFB);
    check_eq("idx_slave2", {29'd0, cur_idx}, 32'd2);
    repeat (3) step();
    s_rdy_ = 8'hFB;
    step();
    s_rdy_ = 8'hFF;
    check_eq("cs_released", {24'd0, s_cs_}, 32'hFF);
    step();

    // Unmapped slave 7
    strobe(30'h3800_0000);
    check_eq("unmapped_err", {31'd0, m_err}, 32'd1);
    check_eq("unmapped_cs", {24'd0, s_cs_}, 32'hFF);
    step();
    step();

    // Timeout on slave 5
    strobe(30'h2800_0000);
    repeat (TIMEOUT + 2) step();
    if (!TO_EN) begin
      s_rdy_ = 8'hDF;
      step();
      s_rdy_ = 8'hFF;
    end
    step();

    // Ready arriving in the last permitted cycle wins
    strobe(30'h2800_0000);
    repeat (TIMEOUT - 1) step();
    s_rdy_ = 8'hDF;
    step();
    s_rdy_ = 8'hFF;
    check_eq("late_ready_idle", {31'd0, busy}, 32'd0);
    repeat (2) step();

    // Reset in the second access cycle
    strobe(30'h1000_0000);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_eq("reset_mid_cs", {24'd0, s_cs_}, 32'hFF);
    step();

    // Back-to-back, ignored strobe, foreign ready
    strobe(30'h1000_0000);
    s_rdy_ = 8'hFB;
    step();
    s_rdy_ = 8'hFF;
    strobe(30'h1800_0000);
    check_eq("b2b_cs_slave3", {24'd0, s_cs_}, 32'hF7);
    m_addr = 30'h2000_0000;
    m_as_  = 1'b0;
    s_rdy_ = 8'hEF;
    repeat (2) step();
    check_eq("guard_cs_slave3", {24'd0, s_cs_}, 32'hF7);
    m_as_  = 1'b1;
    s_rdy_ = 8'hF7;
    step();
    s_rdy_ = 8'hFF;
    step();

    // Randomized traffic
    for (int i = 0; i < 2500; i++) begin
      reset  = ($urandom_range(0, 199) == 0);
      m_as_  = ($urandom_range(0, 2) != 0);
      m_addr = 30'($urandom);
      s_rdy_ = 8'hFF;
      for (int b = 0; b < 8; b++)
        if ($urandom_range(0, 9) == 0) s_rdy_[b] = 1'b0;
      step();
    end
    reset = 1'b0;
    m_as_ = 1'b1;
    s_rdy_ = 8'hFF;
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
